reg_dump_serializer: RTL and testbench

//  Read-side debug port for the 8x32 register file: on a start request it

---
 rtl/reg_dump_serializer.sv | 84 ++++++++
 tb/tb_reg_dump_serializer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/reg_dump_serializer.sv
// reg_dump_serializer: snapshots rf0..rf7 on start and streams a SYNC/data/checksum byte frame
// over a valid/ready handshake.
module reg_dump_serializer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter bit         CSUM_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] rf0,
    input  logic [31:0] rf1,
    input  logic [31:0] rf2,
    input  logic [31:0] rf3,
    input  logic [31:0] rf4,
    input  logic [31:0] rf5,
    input  logic [31:0] rf6,
    input  logic [31:0] rf7,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;
    state_t       state;
    logic [255:0] snap;
    logic [4:0]   cnt;
    logic [7:0]   csum;
    logic [4:0]   nxt;
    assign nxt = cnt + 5'd1;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            snap     <= '0;
            cnt      <= '0;
            csum     <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    snap     <= {rf7, rf6, rf5, rf4, rf3, rf2, rf1, rf0};
                    csum     <= '0;
                    cnt      <= '0;
                    state    <= SYNC;
                    tx_data  <= SYNC_BYTE;
                    tx_valid <= 1'b1;
                    busy     <= 1'b1;
                end
                SYNC: if (tx_ready) begin
                    state   <= DATA;
                    tx_data <= snap[7:0];
                end
                DATA: if (tx_ready) begin
                    csum <= csum ^ tx_data;
                    cnt  <= nxt;
                    if (cnt != 5'd31) begin
                        tx_data <= snap[{nxt, 3'b000} +: 8];
                    end else if (CSUM_EN) begin
                        state   <= CSUM;
                        tx_data <= csum ^ tx_data;
                    end else begin
                        state    <= IDLE;
                        tx_data  <= '0;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                CSUM: if (tx_ready) begin
                    state    <= IDLE;
                    tx_data  <= '0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_serializer.sv
// tb_reg_dump_serializer: directed frame checks on a checksum build (dut) and a no-checksum build (dut0).
module tb_reg_dump_serializer;
    logic        clk = 1'b0, n_rst = 1'b0, start = 1'b0, start0 = 1'b0, tx_ready = 1'b1;
    logic [31:0] rf [8];
    logic [7:0]  tx_data, tx_data0;
    logic        tx_valid, tx_valid0, busy, busy0, done, done0;
    int          total = 0, bad = 0;
    logic [7:0]  got [$];
    int          busy_n, done_n, done_at, stall_bad;

    always #5 clk = ~clk;

    reg_dump_serializer dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .rf0(rf[0]), .rf1(rf[1]), .rf2(rf[2]), .rf3(rf[3]),
        .rf4(rf[4]), .rf5(rf[5]), .rf6(rf[6]), .rf7(rf[7]),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    reg_dump_serializer #(.CSUM_EN(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst), .start(start0),
        .rf0(rf[0]), .rf1(rf[1]), .rf2(rf[2]), .rf3(rf[3]),
        .rf4(rf[4]), .rf5(rf[5]), .rf6(rf[6]), .rf7(rf[7]),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .busy(busy0), .done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    // act: 0 none, 1 corrupt rf0 + start while busy, 2 reset at byte 20, 3 restart in done cycle (dut0)
    task automatic run(input bit sel, input bit pat, input int act);
        bit         acted = 1'b0, prev_stall = 1'b0;
        logic [7:0] prev_d = '0, d;
        logic       v, b, dn;
        got.delete();
        busy_n = 0; done_n = 0; done_at = -1; stall_bad = 0;
        if (sel) start0 = 1'b1; else start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 100; c++) begin
            start = 1'b0; start0 = 1'b0;
            tx_ready = !pat || (c % 4 == 0) || (c % 4 == 3);
            if (act == 1 && c == 0) rf[0] = 32'hFFFFFFFF;
            if (act == 1 && got.size() == 10 && !acted) begin start = 1'b1; acted = 1'b1; end
            if (act == 3 && c == 33) start0 = 1'b1;
            if (act == 2 && got.size() == 20) begin
                chk("pre_rst_valid", tx_valid, 1);
                n_rst = 1'b0;
                #1;
                chk("rst_valid", tx_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_data", tx_data, 0);
                @(negedge clk);
                n_rst = 1'b1;
                @(negedge clk);
                break;
            end
            #1;
            v  = sel ? tx_valid0 : tx_valid;
            d  = sel ? tx_data0 : tx_data;
            b  = sel ? busy0 : busy;
            dn = sel ? done0 : done;
            if (prev_stall && (d !== prev_d || v !== 1'b1)) stall_bad++;
            prev_stall = v && !tx_ready;
            prev_d = d;
            if (v && tx_ready) got.push_back(d);
            if (b) busy_n++;
            if (dn) begin
                if (done_n == 0) done_at = c;
                done_n++;
            end
            @(negedge clk);
        end
        tx_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] acc;
        for (int i = 0; i < 8; i++) rf[i] = '0;
        start = 1'b1; start0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid", tx_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_data", tx_data, 0);
        chk("reset_valid0", tx_valid0, 0);
        n_rst = 1'b1; start = 1'b0; start0 = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {tx_valid, busy, tx_valid0, busy0}, 0);

        rf[0] = 32'h01020304;
        run(0, 0, 0);
        chk("t2_len", got.size(), 34);
        chk("t2_sync", got[0], 8'hA5);
        chk("t2_rf0", {got[4], got[3], got[2], got[1]}, 32'h01020304);
        acc = '0;
        for (int i = 5; i < 33; i++) acc |= got[i];
        chk("t2_zeros", acc, 0);
        chk("t2_csum", got[33], 8'h04);
        chk("t2_busy", busy_n, 34);
        chk("t2_done_n", done_n, 1);
        chk("t2_done_at", done_at, 34);

        rf[0] = '0; rf[7] = 32'hDEADBEEF;
        run(0, 1, 0);
        chk("t3_len", got.size(), 34);
        chk("t3_stall", stall_bad, 0);
        chk("t3_sync", got[0], 8'hA5);
        chk("t3_rf7", {got[32], got[31], got[30], got[29]}, 32'hDEADBEEF);
        chk("t3_csum", got[33], 8'h22);
        chk("t3_done_n", done_n, 1);

        rf[7] = '0; rf[0] = 32'h11223344;
        run(0, 0, 1);
        chk("t4_len", got.size(), 34);
        chk("t4_rf0", {got[4], got[3], got[2], got[1]}, 32'h11223344);
        chk("t4_csum", got[33], 8'h44);
        chk("t4_done_n", done_n, 1);

        rf[0] = 32'h01020304;
        run(0, 0, 2);
        chk("t5_partial", got.size(), 20);
        chk("t5_no_done", done_n, 0);
        chk("t5_idle", {tx_valid, busy, done}, 0);
        run(0, 0, 0);
        chk("t5_len", got.size(), 34);
        chk("t5_sync", got[0], 8'hA5);
        chk("t5_csum", got[33], 8'h04);
        chk("t5_done_n", done_n, 1);

        rf[7] = 32'hDEADBEEF;
        run(1, 0, 3);
        chk("t6_len", got.size(), 66);
        chk("t6_last", got[32], 8'hDE);
        chk("t6_done_at", done_at, 33);
        chk("t6_resync", got[33], 8'hA5);
        chk("t6_rf0", {got[37], got[36], got[35], got[34]}, 32'h01020304);
        chk("t6_last2", got[65], 8'hDE);
        chk("t6_done_n", done_n, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
